// File: rtl/core_featuremap_conv2d_pw.sv
// rtl/core_featuremap_conv2d_pw.sv - pointwise 1x1 convolution core over NCH lockstep channel FIFOs
// Optional CORE_CONV_PW_RELU_EN clamps negative saturated results to zero.
module core_featuremap_conv2d_pw #(
   parameter int DWIDTH = 32,
   parameter int FRAC   = 16,
   parameter int NCH    = 8,
   parameter int NPIX_W = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [NPIX_W-1:0]     npix,
   output logic                  busy,
   output logic                  done,
   input  logic                  cfg_we,
   input  logic [4:0]            cfg_addr,
   input  logic [DWIDTH-1:0]     cfg_wdata,
   input  logic [NCH*DWIDTH-1:0] ff_rdata,
   input  logic [NCH-1:0]        ff_empty,
   output logic                  ff_rdreq,
   output logic [DWIDTH-1:0]     ff_wdata,
   output logic                  ff_wrreq,
   input  logic                  ff_full
);
   localparam int PW = 2 * DWIDTH;
   localparam int AW = PW + $clog2(NCH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_nx;

   logic signed [DWIDTH-1:0] weight [NCH];
   logic signed [DWIDTH-1:0] bias;
   logic [NPIX_W-1:0]        cnt;
   logic                     v1, v2, v3, adv;
   logic signed [PW-1:0]     prod    [NCH];
   logic signed [PW-1:0]     prod_nx [NCH];
   logic signed [AW-1:0]     acc, acc_nx, shifted, sat_max, sat_min;
   logic [DWIDTH-1:0]        result;

   assign adv      = !(v3 && ff_full);
   assign ff_rdreq = (state == RUN) && (ff_empty == '0) && adv;
   assign ff_wrreq = v3 && !ff_full;
   assign busy     = (state != IDLE);

   always_comb begin
      state_nx = state;
      done     = 1'b0;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (ff_rdreq && cnt == NPIX_W'(1)) state_nx = DRAIN;
         DRAIN: begin
            if (!v1 && !v2 && !v3) begin
               state_nx = IDLE;
               done     = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Operands are sign-extended to full product width so the product never wraps.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         logic signed [PW-1:0] xe, we;
         xe = {{DWIDTH{ff_rdata[c*DWIDTH+DWIDTH-1]}}, ff_rdata[c*DWIDTH +: DWIDTH]};
         we = {{DWIDTH{weight[c][DWIDTH-1]}}, weight[c]};
         prod_nx[c] = xe * we;
      end
   end

   always_comb begin
      acc_nx = {{(AW-DWIDTH){bias[DWIDTH-1]}}, bias};
      acc_nx = acc_nx <<< FRAC;
      for (int c = 0; c < NCH; c++)
         acc_nx = acc_nx + {{(AW-PW){prod[c][PW-1]}}, prod[c]};
   end

   always_comb begin
      shifted = acc >>> FRAC;
      sat_max = {{(AW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
      sat_min = {{(AW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};
      if (shifted > sat_max)
         result = {1'b0, {(DWIDTH-1){1'b1}}};
      else if (shifted < sat_min)
         result = {1'b1, {(DWIDTH-1){1'b0}}};
      else
         result = shifted[DWIDTH-1:0];
`ifdef CORE_CONV_PW_RELU_EN
      if (result[DWIDTH-1])
         result = '0;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int c = 0; c < NCH; c++)
            weight[c] <= '0;
         bias <= '0;
      end else if (state == IDLE && cfg_we) begin
         for (int c = 0; c < NCH; c++)
            if (cfg_addr == 5'(c))
               weight[c] <= cfg_wdata;
         if (cfg_addr == 5'(NCH))
            bias <= cfg_wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         v1       <= 1'b0;
         v2       <= 1'b0;
         v3       <= 1'b0;
         acc      <= '0;
         ff_wdata <= '0;
         for (int c = 0; c < NCH; c++)
            prod[c] <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start)
            cnt <= (npix == '0) ? NPIX_W'(1) : npix;
         else if (ff_rdreq)
            cnt <= cnt - NPIX_W'(1);
         // The whole pipe freezes together while the output word is blocked.
         if (adv) begin
            v1 <= ff_rdreq;
            v2 <= v1;
            v3 <= v2;
            for (int c = 0; c < NCH; c++)
               prod[c] <= prod_nx[c];
            acc <= acc_nx;
            if (v2)
               ff_wdata <= result;
         end
      end
   end
endmodule
